// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU execute stage.
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_NOT  = 4'b0101,
    OP_CLR  = 4'b0110,
    OP_CMPE = 4'b0111,
    OP_CMPG = 4'b1000,
    OP_CMPL = 4'b1001,
    OP_SHRA = 4'b1010,
    OP_SHRL = 4'b1011,
    OP_SHL  = 4'b1100,
    OP_JMPI = 4'b1101,
    OP_ILL  = 4'b1110,
    OP_NOP  = 4'b1111
  } alu_op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } exec_state_e;

endpackage

// File: rtl/alu_shift_unit.sv
// Shift unit for the execute stage. Default build shifts one bit per cycle;
// with ALU_EXEC_BARREL_EN defined a combinational barrel shifter finishes on start.
// done_c pulses in the cycle res_c holds the final shifted value.
module alu_shift_unit
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  alu_op_e             op,
  input  logic [DATA_W-1:0]   value,
  input  logic [SHAMT_W-1:0]  amount,
  output logic                done_c,
  output logic [DATA_W-1:0]   res_c
);

`ifdef ALU_EXEC_BARREL_EN

  // Whole shift resolved in the start cycle.
  always_comb begin
    res_c  = value;
    done_c = start;
    case (op)
      OP_SHRA: res_c = DATA_W'($signed(value) >>> amount);
      OP_SHRL: res_c = value >> amount;
      OP_SHL:  res_c = value << amount;
      default: res_c = value;
    endcase
  end

`else

  logic               busy;
  logic [SHAMT_W-1:0] cnt;
  logic [DATA_W-1:0]  val;
  alu_op_e            kind;
  logic [DATA_W-1:0]  step;

  // One-bit shift of the working value.
  always_comb begin
    step = val;
    case (kind)
      OP_SHRA: step = {val[DATA_W-1], val[DATA_W-1:1]};
      OP_SHRL: step = {1'b0, val[DATA_W-1:1]};
      OP_SHL:  step = {val[DATA_W-2:0], 1'b0};
      default: step = val;
    endcase
  end

  // Working register: loaded at start, one bit per cycle, last step returned directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      val  <= '0;
      kind <= OP_SHL;
    end else if (start && (amount != '0)) begin
      busy <= 1'b1;
      cnt  <= amount;
      val  <= value;
      kind <= op;
    end else if (busy) begin
      val <= step;
      cnt <= cnt - SHAMT_W'(1);
      if (cnt == SHAMT_W'(1)) busy <= 1'b0;
    end
  end

  // A zero-amount shift completes immediately with the unshifted operand.
  always_comb begin
    done_c = (start && (amount == '0)) || (busy && (cnt == SHAMT_W'(1)));
    res_c  = busy ? step : value;
  end

`endif

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage: operand-B select, arithmetic/logic/compare, shift sequencing
// and a valid/ready output register. Define ALU_EXEC_BARREL_EN for single-cycle shifts.
module alu_exec
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic              imm_sel,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic [DATA_W-1:0] imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              cmp_flag,
  output logic              err
);

  alu_op_e           op_e;
  logic [DATA_W-1:0] opb;
  logic              accept;
  logic              is_shift;
  exec_state_e       state, state_next;

  logic [DATA_W-1:0] alu_res;
  logic              alu_err;
  logic              cmp_hit;
  logic              cmp_val;

  logic              shift_done;
  logic [DATA_W-1:0] shift_res;

  logic              load;
  logic [DATA_W-1:0] res_next;
  logic              err_next;
  logic              cmp_load;

  assign op_e     = alu_op_e'(op);
  assign opb      = imm_sel ? imm : src_b;
  assign in_ready = !rst && (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_shift = (op_e == OP_SHRA) || (op_e == OP_SHRL) || (op_e == OP_SHL);

  alu_shift_unit u_shift (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && is_shift),
    .op     (op_e),
    .value  (src_a),
    .amount (opb[SHAMT_W-1:0]),
    .done_c (shift_done),
    .res_c  (shift_res)
  );

  // Single-cycle arithmetic, logic and signed compare.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    cmp_hit = 1'b0;
    cmp_val = 1'b0;
    case (op_e)
      OP_ADD:  alu_res = src_a + opb;
      OP_SUB:  alu_res = src_a - opb;
      OP_AND:  alu_res = src_a & opb;
      OP_OR:   alu_res = src_a | opb;
      OP_XOR:  alu_res = src_a ^ opb;
      OP_NOT:  alu_res = ~src_a;
      OP_JMPI: alu_res = src_a;
      OP_CMPE: begin cmp_hit = 1'b1; cmp_val = (src_a == opb); end
      OP_CMPG: begin cmp_hit = 1'b1; cmp_val = ($signed(src_a) > $signed(opb)); end
      OP_CMPL: begin cmp_hit = 1'b1; cmp_val = ($signed(src_a) < $signed(opb)); end
      OP_ILL:  alu_err = 1'b1;
      default: alu_res = '0;
    endcase
    if (cmp_hit) alu_res = DATA_W'(cmp_val);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and result-register load decision.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    res_next   = '0;
    err_next   = 1'b0;
    cmp_load   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_shift) begin
            if (shift_done) begin
              load     = 1'b1;
              res_next = shift_res;
            end else begin
              state_next = SHIFT;
            end
          end else begin
            load     = 1'b1;
            res_next = alu_res;
            err_next = alu_err;
            cmp_load = cmp_hit;
          end
        end
      end
      SHIFT: begin
        if (shift_done) begin
          load       = 1'b1;
          res_next   = shift_res;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output register; held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      err       <= 1'b0;
      cmp_flag  <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        result    <= res_next;
        err       <= err_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (cmp_load) cmp_flag <= cmp_val;
    end
  end

endmodule
